mmio_fifo_ctrl: RTL and testbench

// - MMIO-side controller for the AFU's 64-bit host FIFO. Sits between CCI-P MMIO decode and an

---
 rtl/mmio_fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_ctrl.sv
// mmio_fifo_ctrl: MMIO front-end for a 64-bit show-ahead host FIFO.
// Decodes DATA/STATUS/CTRL/WMARK word addresses, drives push/pop strobes,
// tracks occupancy, keeps sticky ovf/udf flags, runs a sequenced flush and
// returns the c2 read response one cycle after each MMIO read.
// Optional feature: define MMIO_FIFO_WATERMARK_EN for the WMARK register
// and a registered level_hit output.
module mmio_fifo_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 64,
  parameter logic [15:0] ADDR_BASE = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [DATA_W-1:0] mmio_wr_data,
  output logic              rsp_valid,
  output logic [8:0]        rsp_tid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              fifo_push,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              level_hit
);

  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [15:0] A_DATA   = ADDR_BASE;
  localparam logic [15:0] A_STATUS = ADDR_BASE + 16'd2;
  localparam logic [15:0] A_CTRL   = ADDR_BASE + 16'd4;
  localparam logic [15:0] A_WMARK  = ADDR_BASE + 16'd6;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              udf;

  logic              wr_data_hit;
  logic              rd_data_hit;
  logic              ctrl_wr;
  logic              in_idle;
  logic              empty;
  logic              full;
  logic              rd_ok;
  logic              ovf_set;
  logic              udf_set;
  logic [DATA_W-1:0] wmark_rd;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_mux;

  assign wr_data_hit = mmio_wr_valid && (mmio_addr == A_DATA);
  assign rd_data_hit = mmio_rd_valid && (mmio_addr == A_DATA);
  assign ctrl_wr     = mmio_wr_valid && (mmio_addr == A_CTRL);
  assign in_idle     = (state == IDLE);
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign rd_ok       = !empty && in_idle;

  assign fifo_din  = mmio_wr_data;
  assign fifo_push = wr_data_hit && (count < DEPTH_C) && in_idle;
  assign fifo_pop  = (rd_data_hit && rd_ok) || (!in_idle && !empty);

  // A refused DATA access raises the matching sticky error flag.
  assign ovf_set = wr_data_hit && (full || !in_idle);
  assign udf_set = rd_data_hit && (empty || !in_idle);

`ifdef MMIO_FIFO_WATERMARK_EN
  logic [CW-1:0] wmark;

  // Watermark register (clamped to DEPTH) and registered level compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wmark     <= DEPTH_C;
      level_hit <= 1'b0;
    end else begin
      if (mmio_wr_valid && (mmio_addr == A_WMARK)) begin
        wmark <= (mmio_wr_data > DATA_W'(DEPTH)) ? DEPTH_C : mmio_wr_data[CW-1:0];
      end
      level_hit <= (count >= wmark);
    end
  end

  assign wmark_rd = DATA_W'(wmark);
`else
  assign level_hit = 1'b0;
  assign wmark_rd  = '0;
`endif

  // STATUS word: count in [15:8], flags in the low byte.
  always_comb begin
    status              = '0;
    status[0]           = full;
    status[1]           = udf;
    status[2]           = ovf;
    status[3]           = !in_idle;
    status[4]           = level_hit;
    status[8 +: CW]     = count;
  end

  // Read data selected in the request cycle; unmapped addresses read zero.
  always_comb begin
    rd_mux = '0;
    if (mmio_addr == A_DATA) begin
      if (rd_ok) rd_mux = fifo_dout;
    end else if (mmio_addr == A_STATUS) begin
      rd_mux = status;
    end else if (mmio_addr == A_WMARK) begin
      rd_mux = wmark_rd;
    end
  end

  // Occupancy, sticky flags, flush sequencer and the one-cycle read response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_mux;
      end

      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A new error in the same cycle as a clear leaves the flag set.
      ovf <= ovf_set || (ovf && !(ctrl_wr && mmio_wr_data[1]));
      udf <= udf_set || (udf && !(ctrl_wr && mmio_wr_data[1]));

      case (state)
        IDLE:    if (ctrl_wr && mmio_wr_data[0]) state <= FLUSH;
        FLUSH:   if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Scoreboard bench for mmio_fifo_ctrl: a queue-based reference model predicts
// strobes and read responses; a monitor checks responses as they appear.
// Honours MMIO_FIFO_WATERMARK_EN the same way as the design.
module tb_mmio_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam logic [15:0] A_DATA   = 16'h0020;
  localparam logic [15:0] A_STATUS = 16'h0022;
  localparam logic [15:0] A_CTRL   = 16'h0024;
  localparam logic [15:0] A_WMARK  = 16'h0026;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] addr = '0;
  logic [8:0]  tid = '0;
  logic [63:0] wr_data = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        fifo_push;
  logic [63:0] fifo_din;
  logic        fifo_pop;
  logic [63:0] fifo_dout = '0;
  logic        level_hit;

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_BASE(16'h0020)) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(wr_valid), .mmio_rd_valid(rd_valid),
    .mmio_addr(addr), .mmio_tid(tid), .mmio_wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_pop(fifo_pop),
    .fifo_dout(fifo_dout), .level_hit(level_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int push_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- external show-ahead FIFO stub ----------------
  logic [63:0] fq[$];
  logic        s_push, s_pop;
  logic [63:0] s_din;

  always @(negedge clk) begin
    s_push = fifo_push;
    s_pop  = fifo_pop;
    s_din  = fifo_din;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_dout <= '0;
    end else begin
      if (s_pop && fq.size() > 0) void'(fq.pop_front());
      if (s_push) fq.push_back(s_din);
      fifo_dout <= (fq.size() > 0) ? fq[0] : 64'hDEAD_BEEF_0BAD_F00D;
    end
  end

  // ---------------- reference model + scoreboard producer ----------------
  typedef struct {
    int          cyc;
    logic [8:0]  tid;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mq[$];
  bit          m_ovf, m_udf, m_flush, m_lvl;
  int          m_wmark = DEPTH;

  always @(negedge clk) begin
    int          cnt;
    bit          idle, exp_push, exp_pop, ctrl_wr, ovf_set, udf_set, nflush;
    logic [63:0] d;
    exp_t        e;
    if (rst) begin
      mq.delete();
      sb.delete();
      m_ovf = 0; m_udf = 0; m_flush = 0; m_lvl = 0;
      m_wmark = DEPTH;
      chk("rst_push", {63'd0, fifo_push}, 64'd0);
      chk("rst_pop", {63'd0, fifo_pop}, 64'd0);
    end else begin
      cnt  = mq.size();
      idle = !m_flush;
      exp_push = wr_valid && addr == A_DATA && cnt < DEPTH && idle;
      exp_pop  = (rd_valid && addr == A_DATA && cnt > 0 && idle) || (m_flush && cnt > 0);
      chk("fifo_push", {63'd0, fifo_push}, {63'd0, exp_push});
      chk("fifo_pop", {63'd0, fifo_pop}, {63'd0, exp_pop});
      chk("level_hit", {63'd0, level_hit}, {63'd0, m_lvl});
      if (exp_push) begin
        chk("fifo_din", fifo_din, wr_data);
        push_pulses++;
      end

      if (rd_valid) begin
        d = '0;
        if (addr == A_DATA) begin
          if (cnt > 0 && idle) d = mq[0];
        end else if (addr == A_STATUS) begin
          d = (64'(cnt) << 8) + (64'(m_lvl) << 4) + (64'(m_flush) << 3)
            + (64'(m_ovf) << 2) + (64'(m_udf) << 1) + 64'(cnt == DEPTH);
        end else if (addr == A_WMARK) begin
`ifdef MMIO_FIFO_WATERMARK_EN
          d = 64'(m_wmark);
`endif
        end
        e.cyc = cyc; e.tid = tid; e.data = d;
        sb.push_back(e);
      end

      ctrl_wr = wr_valid && addr == A_CTRL;
      ovf_set = wr_valid && addr == A_DATA && (cnt == DEPTH || m_flush);
      udf_set = rd_valid && addr == A_DATA && (cnt == 0 || m_flush);
      if (ctrl_wr && wr_data[1]) begin m_ovf = 0; m_udf = 0; end
      if (ovf_set) m_ovf = 1;
      if (udf_set) m_udf = 1;

      nflush = m_flush;
      if (m_flush) begin
        if (cnt == 0) nflush = 0;
      end else if (ctrl_wr && wr_data[0]) begin
        nflush = 1;
      end
      m_flush = nflush;

`ifdef MMIO_FIFO_WATERMARK_EN
      m_lvl = (cnt >= m_wmark);
      if (wr_valid && addr == A_WMARK)
        m_wmark = (wr_data > 64'(DEPTH)) ? DEPTH : int'(wr_data);
`endif

      if (exp_pop) void'(mq.pop_front());
      if (exp_push) mq.push_back(wr_data);
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_tid", {55'd0, rsp_tid}, 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_latency", 64'(cyc), 64'(e.cyc + 1));
        chk("rsp_tid", {55'd0, rsp_tid}, {55'd0, e.tid});
        chk("rsp_data", rsp_data, e.data);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("rsp_missing", 64'd0, 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit wv, input bit rv, input logic [15:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    wr_valid = wv; rd_valid = rv; addr = a; wr_data = d;
    tid = 9'($urandom_range(0, 511));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 64'h0);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    int          r;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_level_hit", {63'd0, level_hit}, 64'd0);

    // three pushes then three reads, in order
    drive(1, 0, A_DATA, 64'hA);
    drive(1, 0, A_DATA, 64'hB);
    drive(1, 0, A_DATA, 64'hC);
    repeat (3) drive(0, 1, A_DATA, 64'h0);
    idle(2);

    // overfill: nine pushes, only eight accepted
    push_pulses = 0;
    for (int i = 0; i < 9; i++) drive(1, 0, A_DATA, {$urandom, $urandom});
    drive(0, 1, A_STATUS, 64'h0);
    idle(1);
    chk("overfill_push_pulses", 64'(push_pulses), 64'd8);

    // flush with a DATA write and STATUS reads during the flush
    drive(1, 0, A_CTRL, 64'h1);
    drive(1, 0, A_DATA, 64'h55);
    drive(0, 1, A_STATUS, 64'h0);
    drive(1, 1, A_CTRL, 64'h1);
    idle(10);
    drive(0, 1, A_STATUS, 64'h0);
    drive(1, 0, A_CTRL, 64'h2);
    drive(0, 1, A_STATUS, 64'h0);

    // empty read, then clear
    drive(0, 1, A_DATA, 64'h0);
    drive(0, 1, A_STATUS, 64'h0);
    drive(1, 0, A_CTRL, 64'h2);
    drive(0, 1, A_STATUS, 64'h0);

    // simultaneous write and read on empty FIFO
    drive(1, 1, A_DATA, 64'h1234);
    drive(0, 1, A_STATUS, 64'h0);
    drive(0, 1, A_DATA, 64'h0);
    drive(1, 1, A_CTRL, 64'h2);
    drive(0, 1, 16'h0021, 64'h0);
    drive(1, 0, 16'h0030, 64'h77);

    // watermark register and level tracking
    drive(1, 0, A_WMARK, 64'd4);
    for (int i = 0; i < 4; i++) drive(1, 0, A_DATA, 64'(i + 100));
    idle(2);
    drive(0, 1, A_DATA, 64'h0);
    idle(2);
    drive(0, 1, A_WMARK, 64'h0);
    drive(1, 0, A_WMARK, 64'd100);
    drive(0, 1, A_WMARK, 64'h0);
    drive(1, 0, A_WMARK, 64'd2);
    drive(1, 0, A_CTRL, 64'h3);
    idle(6);

    // reset in the middle of a flush with a read outstanding
    for (int i = 0; i < 5; i++) drive(1, 0, A_DATA, {$urandom, $urandom});
    drive(1, 0, A_CTRL, 64'h1);
    drive(0, 1, A_STATUS, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1; wr_valid = 0; rd_valid = 0; addr = '0; wr_data = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midflush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midflush_pop", {63'd0, fifo_pop}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    drive(0, 1, A_STATUS, 64'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      a = A_DATA;
      else if (r == 6) a = A_STATUS;
      else if (r == 7) a = A_CTRL;
      else if (r == 8) a = A_WMARK;
      else             a = ($urandom_range(0, 1) == 1) ? 16'h0021 : 16'h0028;
      if (a == A_CTRL) begin
        d = '0;
        d[0] = ($urandom_range(0, 3) == 0);
        d[1] = ($urandom_range(0, 2) == 0);
      end else if (a == A_WMARK) begin
        d = 64'($urandom_range(0, 12));
      end else begin
        d = {$urandom, $urandom};
      end
      drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45, a, d);
    end

    idle(4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
